// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, constants and GF(2^8) helpers.
// Used by aes_sbox, aes_ks_step and aes_key_sched_seq.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128  = 2'd0,
    KL_192  = 2'd1,
    KL_256  = 2'd2,
    KL_RSVD = 2'd3
  } key_len_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_e;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1B;
  // Word address width; covers every legal depth (44/52/60).
  localparam int ADDR_W = 6;

  function automatic int buf_depth(input int max_nk);
    return 4 * (max_nk + 7);
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 4'd4;
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h00;
    s = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r = r ^ s;
      s = xtime(s);
    end
    return r;
  endfunction

  // Word j of an MSB-aligned key: word 0 sits in [255:224].
  function automatic logic [31:0] key_word(input logic [255:0] key, input int j);
    return key[255 - 32*j -: 32];
  endfunction

endpackage

// File: rtl/aes_ks_step.sv
// One key-schedule step: w_next = w_back ^ f(w_prev), with RotWord/SubWord/Rcon.
module aes_ks_step
  import aes_pkg::*;
(
  input  logic [31:0] w_prev,
  input  logic [31:0] w_back,
  input  logic [2:0]  i_mod_nk,
  input  logic [3:0]  nk,
  input  logic [7:0]  rcon,
  output logic [31:0] w_next
);

  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] t;

  assign sub_in = (i_mod_nk == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in[8*b +: 8]),
      .s (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    if (i_mod_nk == 3'd0)                      t = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && i_mod_nk == 3'd4)   t = sub_out;
    else                                       t = w_prev;
    w_next = w_back ^ t;
  end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse (a^254) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  logic [7:0] pw;
  logic [7:0] inv;

  // NOTE: combinational logic uses blocking '=' so each loop step sees the
  // previous step's value; clocked state elsewhere uses '<=' only.
  always_comb begin
    pw  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_sched_seq.sv
// Iterative AES-128/192/256 key schedule, one word per clock, with a round-key read port.
// Optional AES_KEY_SCHED_ZEROIZE_EN adds a synchronous zeroize input.
module aes_key_sched_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         ready,
  output logic         done,
  output logic         err,
  output logic         key_valid,
  output logic [3:0]   nr,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_data,
  output logic         rd_valid
`ifdef AES_KEY_SCHED_ZEROIZE_EN
  ,
  input  logic         zeroize
`endif
);

  localparam int         DEPTH    = buf_depth(MAX_NK);
  localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [2:0]          imod_q, imod_d;
  logic [3:0]          nk_q, nk_d;
  logic [3:0]          nr_job_q, nr_job_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [31:0]         win_q [MAX_NK];
  logic [31:0]         win_d [MAX_NK];
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                key_valid_q, key_valid_d;
  logic [3:0]          nr_q, nr_d;
  logic [127:0]        rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  logic [31:0]         mem_q [DEPTH];
  logic [31:0]         w_back;
  logic [31:0]         w_next;
  logic [ADDR_W-1:0]   rd_base;
  logic                load_key;
  logic                step_en;
  logic                zero_req;

`ifdef AES_KEY_SCHED_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  // w[i-Nk] is the oldest live entry; the window's newest word is at index 0.
  always_comb begin
    w_back = win_q[0];
    for (int j = 0; j < MAX_NK; j++) begin
      if (j == int'(nk_q) - 1) w_back = win_q[j];
    end
  end

  aes_ks_step u_step (
    .w_prev   (win_q[0]),
    .w_back   (w_back),
    .i_mod_nk (imod_q),
    .nk       (nk_q),
    .rcon     (rcon_q),
    .w_next   (w_next)
  );

  assign rd_base = {rd_idx, 2'b00};

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    imod_d      = imod_q;
    nk_d        = nk_q;
    nr_job_d    = nr_job_q;
    rcon_d      = rcon_q;
    win_d       = win_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    key_valid_d = key_valid_q;
    nr_d        = nr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_en;
    load_key    = 1'b0;
    step_en     = 1'b0;

    if (rd_en) begin
      if (key_valid_q && rd_idx <= nr_q)
        rd_data_d = {mem_q[rd_base], mem_q[rd_base + 6'd1],
                     mem_q[rd_base + 6'd2], mem_q[rd_base + 6'd3]};
      else
        rd_data_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (key_len == KL_RSVD || nk_of(key_len) > MAX_NK_W) begin
            err_d = 1'b1;
          end else begin
            load_key    = 1'b1;
            state_d     = ST_EXPAND;
            nk_d        = nk_of(key_len);
            nr_job_d    = nr_of(key_len);
            last_d      = {nr_of(key_len), 2'b00} + 6'd3;
            idx_d       = {2'b00, nk_of(key_len)};
            imod_d      = 3'd0;
            rcon_d      = RCON_INIT;
            key_valid_d = 1'b0;
            nr_d        = 4'd0;
            for (int j = 0; j < MAX_NK; j++) begin
              win_d[j] = (j < int'(nk_of(key_len)))
                       ? key_word(key_in, int'(nk_of(key_len)) - 1 - j) : 32'h0;
            end
          end
        end
      end
      ST_EXPAND: begin
        step_en  = 1'b1;
        win_d[0] = w_next;
        for (int j = 1; j < MAX_NK; j++) win_d[j] = win_q[j-1];
        idx_d  = idx_q + 6'd1;
        imod_d = ({1'b0, imod_q} == nk_q - 4'd1) ? 3'd0 : imod_q + 3'd1;
        if (imod_q == 3'd0) rcon_d = xtime(rcon_q);
        if (idx_q == last_q) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          key_valid_d = 1'b1;
          nr_d        = nr_job_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (zero_req) begin
      state_d     = ST_IDLE;
      rcon_d      = 8'h00;
      for (int j = 0; j < MAX_NK; j++) win_d[j] = 32'h0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      key_valid_d = 1'b0;
      nr_d        = 4'd0;
      rd_data_d   = '0;
      rd_valid_d  = 1'b0;
      load_key    = 1'b0;
      step_en     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      imod_q      <= '0;
      nk_q        <= '0;
      nr_job_q    <= '0;
      rcon_q      <= '0;
      for (int j = 0; j < MAX_NK; j++) win_q[j] <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      key_valid_q <= 1'b0;
      nr_q        <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      imod_q      <= imod_d;
      nk_q        <= nk_d;
      nr_job_q    <= nr_job_d;
      rcon_q      <= rcon_d;
      win_q       <= win_d;
      done_q      <= done_d;
      err_q       <= err_d;
      key_valid_q <= key_valid_d;
      nr_q        <= nr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // NOTE: the word buffer has no reset; key_valid gates every read, so stale
  // contents are never visible and the array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (zero_req) begin
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= 32'h0;
    end else if (load_key) begin
      for (int j = 0; j < MAX_NK; j++) begin
        if (j < int'(nk_of(key_len))) mem_q[j] <= key_word(key_in, j);
      end
    end else if (step_en) begin
      mem_q[idx_q] <= w_next;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign key_valid = key_valid_q;
  assign nr        = nr_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule
